// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared state encodings and tap helper for the CPU clock-enable controller.
package cpu_clock_ctrl_pkg;

    localparam logic [1:0] S_PAUSE = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam int DEF_RATE_STEP = 4;

    // Divider bit watched for a given rate code; code 3 is the fastest (lowest) tap.
    function automatic int tap_index(input int div_width, input int rate_step,
                                     input logic [1:0] sel);
        return div_width - 1 - rate_step * int'(sel);
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stability counter for a raw switch or button.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_db
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_s1, r_s2, r_db;
    logic [CW-1:0] r_cnt;

    // Any sample matching the current output restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_din;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator: rate divider, run/pause/step/halt FSM, ce counter.
// Optional breakpoint support when CPU_CLOCK_CTRL_BREAK_EN is defined.
module cpu_clock_ctrl
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH       = 24,
    parameter int RATE_STEP       = DEF_RATE_STEP,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_sw,
    input  logic                 step_btn,
    input  logic [1:0]           rate_sel,
    input  logic                 halt_req,
    output logic                 cpu_ce,
    output logic [1:0]           state_out,
    output logic [CNT_WIDTH-1:0] ce_count
`ifdef CPU_CLOCK_CTRL_BREAK_EN
    ,
    input  logic [7:0]           pc,
    input  logic [7:0]           break_addr,
    input  logic                 break_valid
`endif
);
    localparam int TAP_W = (DIV_WIDTH > 1) ? $clog2(DIV_WIDTH) : 1;

    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic [1:0]           r_rate_sel_q;
    logic                 r_tap_prev;
    logic                 r_step_db_q;
    logic [1:0]           r_state;
    logic                 r_ce;
    logic [CNT_WIDTH-1:0] r_ce_count;

    logic [TAP_W-1:0]     w_tap, w_tap_new;
    logic                 w_tap_bit, w_tap_new_bit, w_rate_chg;
    logic                 w_run_tick, w_step_rise, w_break_hit;
    logic                 w_run_db, w_step_db;
    logic [1:0]           w_state_nxt;
    logic                 w_ce_nxt;

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk(clk), .rst(rst), .i_din(run_sw), .o_db(w_run_db)
    );

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk(clk), .rst(rst), .i_din(step_btn), .o_db(w_step_db)
    );

    assign w_tap         = TAP_W'(tap_index(DIV_WIDTH, RATE_STEP, r_rate_sel_q));
    assign w_tap_new     = TAP_W'(tap_index(DIV_WIDTH, RATE_STEP, rate_sel));
    assign w_tap_bit     = r_div_cnt[w_tap];
    assign w_tap_new_bit = r_div_cnt[w_tap_new];
    assign w_rate_chg    = (rate_sel != r_rate_sel_q);
    // A rate switch reseeds the edge detector from the new tap, so the switch cycle never ticks.
    assign w_run_tick    = w_tap_bit & ~r_tap_prev & ~w_rate_chg;
    assign w_step_rise   = w_step_db & ~r_step_db_q;

`ifdef CPU_CLOCK_CTRL_BREAK_EN
    assign w_break_hit = break_valid && (pc == break_addr);
`else
    assign w_break_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_rate_sel_q <= 2'd0;
            r_tap_prev   <= 1'b0;
            r_step_db_q  <= 1'b0;
        end else begin
            r_div_cnt    <= r_div_cnt + DIV_WIDTH'(1);
            r_rate_sel_q <= rate_sel;
            r_tap_prev   <= w_rate_chg ? w_tap_new_bit : w_tap_bit;
            r_step_db_q  <= w_step_db;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ce_nxt    = 1'b0;
        case (r_state)
            S_PAUSE: begin
                if (w_run_db) begin
                    w_state_nxt = S_RUN;
                end else if (w_step_rise) begin
                    w_ce_nxt    = 1'b1;
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                if (!w_step_db) w_state_nxt = S_PAUSE;
            end
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (!w_run_db || w_break_hit) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_run_tick) begin
                    w_ce_nxt = 1'b1;
                end
            end
            default: begin
                if (!w_run_db && !w_step_db) w_state_nxt = S_PAUSE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_PAUSE;
            r_ce       <= 1'b0;
            r_ce_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ce    <= w_ce_nxt;
            if (w_ce_nxt) r_ce_count <= r_ce_count + CNT_WIDTH'(1);
        end
    end

    assign cpu_ce    = r_ce;
    assign state_out = r_state;
    assign ce_count  = r_ce_count;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with small divider/debounce parameters.
module tb_cpu_clock_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_sw = 1'b0, step_btn = 1'b0, halt_req = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic       cpu_ce;
    logic [1:0] state_out;
    logic [3:0] ce_count;
`ifdef CPU_CLOCK_CTRL_BREAK_EN
    logic [7:0] pc = 8'd0, break_addr = 8'd0;
    logic       break_valid = 1'b0;
`endif

    int n_cmp = 0, n_err = 0;
    int cyc = 0, dcnt = 0, n_ce = 0, last_ce_cyc = 0, last_gap = 0, consec = 0;
    bit prev_ce = 1'b0;

    cpu_clock_ctrl #(.DIV_WIDTH(8), .RATE_STEP(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn), .rate_sel(rate_sel),
        .halt_req(halt_req), .cpu_ce(cpu_ce), .state_out(state_out), .ce_count(ce_count)
`ifdef CPU_CLOCK_CTRL_BREAK_EN
        , .pc(pc), .break_addr(break_addr), .break_valid(break_valid)
`endif
    );

    always #5 clk = ~clk;

    // Pulse monitor and divider reference, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        dcnt = rst ? 0 : (dcnt + 1) % 256;
        if (cpu_ce) begin
            if (prev_ce) consec++;
            last_gap    = cyc - last_ce_cyc;
            last_ce_cyc = cyc;
            n_ce++;
        end
        prev_ce = cpu_ce;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_state(input int exp, input int budget, input string tag);
        int k = 0;
        while (int'(state_out) != exp && k < budget) begin @(negedge clk); k++; end
        chk(tag, int'(state_out), exp);
    endtask

    task automatic wait_ce(input int target, input int budget, input string tag);
        int k = 0;
        while (n_ce < target && k < budget) begin @(negedge clk); k++; end
        chk(tag, n_ce, target);
    endtask

    task automatic wait_dcnt_mod(input int m, input int r, input int budget, input string tag);
        int k = 0;
        while ((dcnt % m) != r && k < budget) begin @(negedge clk); k++; end
        chk(tag, dcnt % m, r);
    endtask

    initial begin
        int n0, c0;
        repeat (3) @(negedge clk);
        chk("reset_ce", int'(cpu_ce), 0);
        chk("reset_count", int'(ce_count), 0);
        chk("reset_state", int'(state_out), 0);
        rst = 1'b0;

        // Free run at the fastest rate: tap 1, one ce every 4 clk.
        rate_sel = 2'd3;
        run_sw   = 1'b1;
        wait_state(1, 20, "run_enter");
        n0 = n_ce;
        wait_ce(n0 + 10, 100, "run_10_ce");
        chk("run_count", int'(ce_count), 10);
        chk("run_gap", last_gap, 4);

        // Switch to the slowest rate where bit7 is already high and bit1 has no edge.
        wait_dcnt_mod(256, 132, 300, "rate_align");
        rate_sel = 2'd0;
        c0 = cyc;
        n0 = n_ce;
        wait_ce(n0 + 1, 300, "rate_first_seen");
        chk("rate_first_delay", last_ce_cyc - c0, 253);
        wait_ce(n0 + 2, 300, "rate_second_seen");
        chk("rate_gap", last_gap, 256);

        // Pause, then step: a long press gives one ce, a short glitch none.
        run_sw = 1'b0;
        wait_state(0, 20, "pause_enter");
        n0 = n_ce;
        step_btn = 1'b1;
        repeat (30) @(negedge clk);
        chk("step_hold_state", int'(state_out), 2);
        repeat (20) @(negedge clk);
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("step_one_ce", n_ce - n0, 1);
        chk("step_back_pause", int'(state_out), 0);
        n0 = n_ce;
        step_btn = 1'b1;
        repeat (3) @(negedge clk);
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_no_ce", n_ce - n0, 0);
        chk("count_vs_pulses", int'(ce_count), n_ce % 16);

        // Halt raised during a tick cycle at the fast rate.
        rate_sel = 2'd3;
        run_sw   = 1'b1;
        wait_state(1, 20, "halt_run_enter");
        repeat (2) @(negedge clk);
        wait_dcnt_mod(4, 2, 10, "halt_align");
        n0 = n_ce;
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        chk("halt_state", int'(state_out), 3);
        chk("halt_tick_no_ce", n_ce - n0, 0);
        repeat (20) @(negedge clk);
        chk("halt_holds", int'(state_out), 3);
        chk("halt_no_ce", n_ce - n0, 0);
        run_sw = 1'b0;
        wait_state(0, 20, "halt_exit");

        // Reset mid-run, then wrap the 4-bit counter.
        run_sw = 1'b1;
        wait_state(1, 20, "wrap_run_enter");
        n0 = n_ce;
        wait_ce(n0 + 2, 50, "pre_reset_ce");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_rst_ce", int'(cpu_ce), 0);
        chk("midrun_rst_count", int'(ce_count), 0);
        chk("midrun_rst_state", int'(state_out), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_state(1, 20, "post_reset_run");
        n0 = n_ce;
        wait_ce(n0 + 17, 200, "wrap_17_ce");
        chk("wrap_count", int'(ce_count), 1);

`ifdef CPU_CLOCK_CTRL_BREAK_EN
        pc          = 8'h42;
        break_addr  = 8'h42;
        break_valid = 1'b1;
        @(negedge clk);
        n0 = n_ce;
        repeat (30) @(negedge clk);
        chk("break_no_ce", n_ce - n0, 0);
        break_valid = 1'b0;
`endif

        chk("no_back_to_back", consec, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
